// File: rtl/moments_accum.sv
// Streaming binary-image moment accumulator (m00, m10, m01) over an AXI4-Stream video frame.
// Optional region-of-interest row window selected by the MOMENTS_ROI_EN macro.
module moments_accum #(
  parameter int PIX_W = 8,
  parameter int ROWS  = 480,
  parameter int COLS  = 640,
  parameter int ACC_W = 40
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [PIX_W-1:0]        s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic [PIX_W-1:0]        thresh,
`ifdef MOMENTS_ROI_EN
  input  logic [$clog2(ROWS)-1:0] roi_y0,
  input  logic [$clog2(ROWS)-1:0] roi_y1,
`endif
  output logic [ACC_W-1:0]        m00,
  output logic [ACC_W-1:0]        m10,
  output logic [ACC_W-1:0]        m01,
  output logic                    res_valid,
  input  logic                    res_ack,
  output logic                    overrun,
  output logic                    sof_err,
  output logic                    dbg_state_o
);

  localparam int X_W = $clog2(COLS) + 1;
  localparam int Y_W = $clog2(ROWS) + 1;
  localparam logic [X_W-1:0] COLS_X    = X_W'(COLS);
  localparam logic [Y_W-1:0] LAST_ROW  = Y_W'(ROWS - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [ACC_W-1:0] a00_q, a00_d, a10_q, a10_d, a01_q, a01_d;
  logic [ACC_W-1:0] m00_q, m00_d, m10_q, m10_d, m01_q, m01_d;
  logic             res_valid_q, res_valid_d;
  logic             overrun_q, overrun_d;
  logic             sof_err_q, sof_err_d;

  logic             accept, sof, active, counted, in_roi, frame_done;
  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic [ACC_W-1:0] base00, base10, base01, sum00, sum10, sum01;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // Handshake: a beat transfers when tvalid && tready; tready follows ARESETN, so the
  // stream is never back-pressured while out of reset.
  assign s_axis_tready = ARESETN;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign sof           = accept & s_axis_tuser;
  assign active        = accept & (sof | (state_q == ACCUM));

`ifdef MOMENTS_ROI_EN
  assign in_roi = (cur_y >= Y_W'(roi_y0)) && (cur_y <= Y_W'(roi_y1));
`else
  assign in_roi = 1'b1;
`endif

  always_comb begin
    cur_x  = sof ? '0 : x_q;
    cur_y  = sof ? '0 : y_q;
    base00 = sof ? '0 : a00_q;
    base10 = sof ? '0 : a10_q;
    base01 = sof ? '0 : a01_q;

    counted    = active && (s_axis_tdata >= thresh) && (cur_x < COLS_X) && in_roi;
    sum00      = counted ? sat_add(base00, ACC_W'(1))     : base00;
    sum10      = counted ? sat_add(base10, ACC_W'(cur_x)) : base10;
    sum01      = counted ? sat_add(base01, ACC_W'(cur_y)) : base01;
    frame_done = active && s_axis_tlast && (cur_y == LAST_ROW);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    a00_d       = a00_q;
    a10_d       = a10_q;
    a01_d       = a01_q;
    m00_d       = m00_q;
    m10_d       = m10_q;
    m01_d       = m01_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    sof_err_d   = sof_err_q;

    if (active) begin
      a00_d   = sum00;
      a10_d   = sum10;
      a01_d   = sum01;
      state_d = ACCUM;
      if (s_axis_tlast) begin
        x_d = '0;
        y_d = cur_y + 1'b1;
      end else begin
        // x saturates so over-long lines can never wrap back into the counted range
        x_d = (cur_x == '1) ? cur_x : cur_x + 1'b1;
        y_d = cur_y;
      end
    end

    if (frame_done) begin
      state_d     = IDLE;
      x_d         = '0;
      y_d         = '0;
      m00_d       = sum00;
      m10_d       = sum10;
      m01_d       = sum01;
      res_valid_d = 1'b1;
      overrun_d   = res_valid_q & ~res_ack;
    end else if (res_ack) begin
      res_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (sof && (state_q == ACCUM)) begin
      sof_err_d = 1'b1;
    end else if (res_ack) begin
      sof_err_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      a00_q       <= '0;
      a10_q       <= '0;
      a01_q       <= '0;
      m00_q       <= '0;
      m10_q       <= '0;
      m01_q       <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      a00_q       <= a00_d;
      a10_q       <= a10_d;
      a01_q       <= a01_d;
      m00_q       <= m00_d;
      m10_q       <= m10_d;
      m01_q       <= m01_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign m00         = m00_q;
  assign m10         = m10_q;
  assign m01         = m01_q;
  assign res_valid   = res_valid_q;
  assign overrun     = overrun_q;
  assign sof_err     = sof_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_moments_accum.sv
// Bench for moments_accum on a 4x4 frame: a wide instance and a 4-bit saturating instance share stimulus.
module tb_moments_accum;
  localparam int PIX_W = 8;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ACC_W = 40;
  localparam int SAT_W = 4;

  logic             ACLK = 1'b0;
  logic             ARESETN;
  logic [PIX_W-1:0] s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tuser, s_axis_tlast;
  logic             s_axis_tready, sat_tready;
  logic [PIX_W-1:0] thresh;
  logic             res_ack;
  logic [ACC_W-1:0] m00, m10, m01;
  logic             res_valid, overrun, sof_err, dbg_state;
  logic [SAT_W-1:0] s_m00, s_m10, s_m01;
  logic             s_res_valid, s_overrun, s_sof_err, s_dbg_state;

  int roi_lo = 0;
  int roi_hi = ROWS - 1;
`ifdef MOMENTS_ROI_EN
  logic [1:0] roi_y0, roi_y1;
  assign roi_y0 = 2'(roi_lo);
  assign roi_y1 = 2'(roi_hi);
`endif

  moments_accum #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .thresh(thresh),
`ifdef MOMENTS_ROI_EN
    .roi_y0(roi_y0), .roi_y1(roi_y1),
`endif
    .m00(m00), .m10(m10), .m01(m01), .res_valid(res_valid), .res_ack(res_ack),
    .overrun(overrun), .sof_err(sof_err), .dbg_state_o(dbg_state)
  );

  moments_accum #(.PIX_W(PIX_W), .ROWS(ROWS), .COLS(COLS), .ACC_W(SAT_W)) dut_sat (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(sat_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .thresh(thresh),
`ifdef MOMENTS_ROI_EN
    .roi_y0(roi_y0), .roi_y1(roi_y1),
`endif
    .m00(s_m00), .m10(s_m10), .m01(s_m01), .res_valid(s_res_valid), .res_ack(res_ack),
    .overrun(s_overrun), .sof_err(s_sof_err), .dbg_state_o(s_dbg_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  logic [3*ACC_W-1:0] exp_q[$];
  logic [3*SAT_W-1:0] exp_sat_q[$];
  logic [PIX_W-1:0]   img[ROWS][COLS];
  logic [PIX_W-1:0]   thr[ROWS][COLS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic [PIX_W-1:0] d, input logic [PIX_W-1:0] th,
                            input bit user, input bit last, input bit ack);
    s_axis_tdata  = d;
    thresh        = th;
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    res_ack       = ack;
    s_axis_tvalid = 1'b1;
    @(posedge ACLK);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    res_ack       = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_ack();
    res_ack = 1'b1;
    @(posedge ACLK);
    #1;
    res_ack = 1'b0;
  endtask

  function automatic logic [SAT_W-1:0] clip(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] mx;
    mx = ACC_W'((1 << SAT_W) - 1);
    return (v > mx) ? mx[SAT_W-1:0] : v[SAT_W-1:0];
  endfunction

  task automatic model(output logic [ACC_W-1:0] e00, output logic [ACC_W-1:0] e10,
                       output logic [ACC_W-1:0] e01);
    e00 = '0; e10 = '0; e01 = '0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (img[y][x] >= thr[y][x] && y >= roi_lo && y <= roi_hi) begin
          e00 += 1;
          e10 += ACC_W'(x);
          e01 += ACC_W'(y);
        end
  endtask

  task automatic fill_const(input logic [PIX_W-1:0] px, input logic [PIX_W-1:0] th);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        img[y][x] = px;
        thr[y][x] = th;
      end
  endtask

  task automatic fill_random();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        img[y][x] = PIX_W'($urandom_range(0, 255));
        thr[y][x] = PIX_W'($urandom_range(0, 255));
      end
  endtask

  // Sends one full frame (extra pixels beyond COLS per line are bright and must be ignored),
  // then compares the result that appears one cycle after the completing beat.
  task automatic run_frame(input string name, input bit ack_last, input int extra);
    logic [ACC_W-1:0]   e00, e10, e01;
    logic [3*ACC_W-1:0] e;
    logic [3*SAT_W-1:0] es;
    model(e00, e10, e01);
    exp_q.push_back({e00, e10, e01});
    exp_sat_q.push_back({clip(e00), clip(e10), clip(e01)});
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS + extra; x++)
        drive_beat((x < COLS) ? img[y][x] : 8'hFF, (x < COLS) ? thr[y][x] : 8'h00,
                   (x == 0 && y == 0), (x == COLS + extra - 1),
                   ack_last && (y == ROWS - 1) && (x == COLS + extra - 1));
    e  = exp_q.pop_front();
    es = exp_sat_q.pop_front();
    check({name, " m00"}, m00, e[3*ACC_W-1:2*ACC_W]);
    check({name, " m10"}, m10, e[2*ACC_W-1:ACC_W]);
    check({name, " m01"}, m01, e[ACC_W-1:0]);
    check({name, " res_valid"}, res_valid, 1);
    check({name, " state idle"}, dbg_state, 0);
    check({name, " sat m00"}, s_m00, es[3*SAT_W-1:2*SAT_W]);
    check({name, " sat m10"}, s_m10, es[2*SAT_W-1:SAT_W]);
    check({name, " sat m01"}, s_m01, es[SAT_W-1:0]);
  endtask

  initial begin
    ARESETN = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    thresh = '0; res_ack = 1'b0;
    #1;
    check("rst m00", m00, 0);
    check("rst res_valid", res_valid, 0);
    check("rst overrun", overrun, 0);
    check("rst sof_err", sof_err, 0);
    check("rst tready", s_axis_tready, 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("tready up", s_axis_tready, 1);

    // beats without tuser while idle are dropped: four tlasts must not complete a frame
    for (int i = 0; i < 4; i++) drive_beat(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    check("idle discard res_valid", res_valid, 0);
    check("idle discard m00", m00, 0);

    // single bright pixel at (2,3)
    fill_const(8'h00, 8'd128);
    img[3][2] = 8'hFF;
    run_frame("single", 1'b0, 0);
    check("single overrun", overrun, 0);
    idle_cycles(3);
    check("hold m10", m10, 2);
    pulse_ack();
    check("ack res_valid", res_valid, 0);
    check("ack hold m01", m01, 3);

    // all bright, threshold 0
    fill_const(8'hFF, 8'h00);
    run_frame("all255", 1'b0, 0);
    pulse_ack();
    check("all255 ack res_valid", res_valid, 0);

    // two completions without ack -> overrun, second frame shown
    fill_random();
    run_frame("rand_a", 1'b0, 0);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        img[y][x] = PIX_W'(100 + x - y);
        thr[y][x] = 8'd100;
      end
    run_frame("boundary", 1'b0, 0);
    check("overrun set", overrun, 1);
    pulse_ack();
    check("overrun clr", overrun, 0);
    check("overrun ack res_valid", res_valid, 0);

    // over-long lines, then completion coincident with ack
    fill_random();
    run_frame("extra_cols", 1'b0, 2);
    check("extra overrun", overrun, 0);
    fill_random();
    run_frame("ack_coinc", 1'b1, 0);
    check("ack_coinc overrun", overrun, 0);
    pulse_ack();

    // restart mid-frame after 5 beats
    drive_beat(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    check("accum state", dbg_state, 1);
    for (int i = 0; i < 4; i++) drive_beat(8'hFF, 8'h00, 1'b0, (i == 2), 1'b0);
    fill_const(8'hFF, 8'h00);
    img[0][0] = 8'h00;
    run_frame("restart", 1'b0, 0);
    check("sof_err set", sof_err, 1);
    pulse_ack();
    check("sof_err clr", sof_err, 0);

    // asynchronous reset during line 2
    fill_const(8'hFF, 8'h00);
    for (int i = 0; i < 2 * COLS + 2; i++)
      drive_beat(8'hFF, 8'h00, (i == 0), ((i % COLS) == COLS - 1), 1'b0);
    #2 ARESETN = 1'b0;
    #1;
    check("midrst m00", m00, 0);
    check("midrst m10", m10, 0);
    check("midrst m01", m01, 0);
    check("midrst res_valid", res_valid, 0);
    check("midrst tready", s_axis_tready, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    fill_random();
    run_frame("post_rst", 1'b0, 0);
    check("post_rst overrun", overrun, 0);

`ifdef MOMENTS_ROI_EN
    pulse_ack();
    roi_lo = 1;
    roi_hi = 1;
    fill_const(8'hFF, 8'h00);
    run_frame("roi", 1'b0, 0);
    check("roi m00 const", m00, 4);
`endif

    check("scoreboard empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moments_accum.md
MOMENTS_ACCUM -- requirements
Module: moments_accum

Interface
REQ-001 Parameter PIX_W, default 8, pixel data width in bits.
REQ-002 Parameter ROWS, default 480, lines per frame.
REQ-003 Parameter COLS, default 640, pixels per line.
REQ-004 Parameter ACC_W, default 40, width of every moment accumulator.
REQ-005 ACLK  in  1  sole clock; all logic on the rising edge.
REQ-006 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 s_axis_tdata  in  PIX_W  grey pixel.
REQ-008 s_axis_tvalid  in  1  pixel valid.
REQ-009 s_axis_tready  out  1  pixel accepted.
REQ-010 s_axis_tuser  in  1  start of frame, marks pixel (0,0).
REQ-011 s_axis_tlast  in  1  end of line.
REQ-012 thresh  in  PIX_W  binarisation threshold, driven from the register file.
REQ-013 m00, m10, m01  out  ACC_W each  latched moments of the last complete frame.
REQ-014 res_valid  out  1  latched result present.
REQ-015 res_ack  in  1  single-cycle pulse from the register file; consumes the result.
REQ-016 overrun  out  1  sticky; a result was overwritten before it was acknowledged.
REQ-017 sof_err  out  1  sticky; tuser arrived mid-frame.

Function
REQ-018 A beat is accepted on tvalid && tready; tready SHALL be 1 whenever ARESETN=1 (the block never stalls).
REQ-019 States SHALL be IDLE and ACCUM; beats accepted in IDLE without tuser SHALL be discarded.
REQ-020 An accepted beat with tuser SHALL clear the accumulators, set x=0 and y=0, process the beat, and enter ACCUM, from either state.
REQ-021 A beat is foreground when tdata >= thresh (unsigned compare).
REQ-022 For a foreground beat at (x,y): m00 += 1, m10 += x, m01 += y.
REQ-023 Each accumulator SHALL saturate at all-ones and not wrap.
REQ-024 x SHALL increment per accepted beat.
REQ-025 Beats with x >= COLS SHALL be ignored for statistics.
REQ-026 x SHALL return to 0 after a beat with tlast.
REQ-027 y SHALL increment on tlast.
REQ-028 The frame completes on a tlast beat with y = ROWS-1.
REQ-029 One cycle after the completing beat, the final sums, including that beat, SHALL appear on m00/m10/m01.
REQ-030 In the same cycle res_valid SHALL go to 1 and the state SHALL return to IDLE.
REQ-031 res_ack SHALL clear res_valid and overrun on the next edge.
REQ-032 m00/m10/m01 SHALL hold their value until the next frame completes.
REQ-033 A frame completing while res_valid=1 and res_ack=0 SHALL overwrite the outputs and set overrun.
REQ-034 A frame completing in the same cycle as res_ack SHALL leave res_valid=1 with the new data and overrun=0.
REQ-035 tuser accepted in ACCUM (restart) SHALL set sof_err; sof_err clears only on res_ack.
REQ-036 thresh SHALL be sampled per beat with no latency.

Reset
REQ-037 ARESETN=0 SHALL asynchronously force IDLE, x=y=0, all accumulators=0, m00=m10=m01=0, res_valid=0, overrun=0, sof_err=0, tready=0.
REQ-038 Reset mid-frame SHALL discard the partial frame; no result is produced for it.

Configuration
REQ-039 Macro MOMENTS_ROI_EN SHALL select region-of-interest support.
REQ-040 With MOMENTS_ROI_EN defined: inputs roi_y0 and roi_y1 are added (width clog2(ROWS) each); a foreground beat counts only if roi_y0 <= y <= roi_y1.
REQ-041 Without MOMENTS_ROI_EN: the ports are absent and every row counts.

Verification
REQ-042 Frame of 4x4 (ROWS=COLS=4), single pixel 255 at (x=2,y=3), thresh=128 -> m00=1, m10=2, m01=3, res_valid=1 one cycle after the final tlast.
REQ-043 All-255 4x4 frame, thresh=0 -> m00=16, m10=24, m01=24; res_ack pulse -> res_valid=0 next cycle.
REQ-044 Two frames with no ack between them -> second frame's results shown, overrun=1; ack clears it; ack coincident with a third completion -> res_valid=1, overrun=0.
REQ-045 tuser mid-frame after 5 beats, then a full frame -> sof_err=1, results reflect only the restarted frame.
REQ-046 ARESETN low during line 2 -> all outputs 0 immediately; next full frame produces correct moments.
REQ-047 MOMENTS_ROI_EN, roi_y0=roi_y1=1, all-255 4x4 frame -> m00=4, m10=6, m01=4.
